timer_sched: RTL and testbench



---
 rtl/timer_sched_pkg.sv | 28 ++
 rtl/timer_sched_slots.sv | 66 ++++++
 rtl/timer_sched.sv | 142 ++++++++++++++
 tb/tb_timer_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer scheduler.
// Defining TIMER_SCHED_PERIODIC_EN adds a per-slot reload period.
package timer_sched_pkg;

    // Slot storage is sized for the widest supported time value; TIME_W must not exceed it.
    localparam int TIME_W_MAX = 64;
    localparam logic [TIME_W_MAX-1:0] TIME_ALL_ONES = '1;

    typedef enum logic {
        OP_ARM    = 1'b0,
        OP_CANCEL = 1'b1
    } req_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FIRE
    } state_e;

    typedef struct packed {
        logic                  armed;
        logic [TIME_W_MAX-1:0] deadline;
`ifdef TIMER_SCHED_PERIODIC_EN
        logic [TIME_W_MAX-1:0] period;
`endif
    } slot_t;

endpackage

// File: rtl/timer_sched_slots.sv
// Slot register file: arm/cancel/retire write ports and one indexed read port for the scan.
// With TIMER_SCHED_PERIODIC_EN, retiring a slot with a nonzero period reloads it instead.
module timer_sched_slots
    import timer_sched_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TIME_W    = 64,
    localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm_en,
    input  logic [SLOT_W-1:0]    arm_slot,
    input  logic [TIME_W-1:0]    arm_deadline,
`ifdef TIMER_SCHED_PERIODIC_EN
    input  logic [TIME_W-1:0]    arm_period,
`endif
    input  logic                 cancel_en,
    input  logic [SLOT_W-1:0]    cancel_slot,
    input  logic                 retire_en,
    input  logic [SLOT_W-1:0]    retire_slot,
    input  logic [SLOT_W-1:0]    rd_idx,
    output logic                 rd_armed,
    output logic [TIME_W-1:0]    rd_deadline,
    output logic [NUM_SLOTS-1:0] armed
);

    slot_t slots [NUM_SLOTS];

    // The FSM guarantees at most one of arm/cancel/retire per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (arm_en) begin
            slots[arm_slot].armed    <= 1'b1;
            slots[arm_slot].deadline <= TIME_W_MAX'(arm_deadline);
`ifdef TIMER_SCHED_PERIODIC_EN
            slots[arm_slot].period   <= TIME_W_MAX'(arm_period);
`endif
        end else if (cancel_en) begin
            slots[cancel_slot].armed <= 1'b0;
        end else if (retire_en) begin
`ifdef TIMER_SCHED_PERIODIC_EN
            if (slots[retire_slot].period != '0) begin
                slots[retire_slot].deadline <= slots[retire_slot].deadline
                                             + slots[retire_slot].period;
            end else begin
                slots[retire_slot].armed <= 1'b0;
            end
`else
            slots[retire_slot].armed <= 1'b0;
`endif
        end
    end

    always_comb begin
        rd_armed    = slots[rd_idx].armed;
        rd_deadline = TIME_W'(slots[rd_idx].deadline);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            armed[i] = slots[i].armed;
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Multiplexes NUM_SLOTS timer deadlines onto one mtimecmp via a sequential min-scan.
// TIMER_SCHED_PERIODIC_EN adds req_period_i for auto-reloading slots.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TIME_W    = 64,
    localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [TIME_W-1:0]    mtime_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_op_i,
    input  logic [SLOT_W-1:0]    req_slot_i,
    input  logic [TIME_W-1:0]    req_deadline_i,
`ifdef TIMER_SCHED_PERIODIC_EN
    input  logic [TIME_W-1:0]    req_period_i,
`endif
    output logic [TIME_W-1:0]    mtimecmp_o,
    output logic                 cmp_valid_o,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [SLOT_W-1:0]    evt_slot_o,
    output logic [NUM_SLOTS-1:0] armed_o
);

    state_e              state, state_nxt;
    logic [SLOT_W-1:0]   scan_idx;
    logic                run_found, next_found;
    logic [TIME_W-1:0]   run_dl, next_dl;
    logic [SLOT_W-1:0]   run_idx, next_idx, best_idx;
    logic                rd_armed, take, last, expired;
    logic [TIME_W-1:0]   rd_deadline;
    logic                arm_en, cancel_en, retire_en, scan_start;

    timer_sched_slots #(
        .NUM_SLOTS (NUM_SLOTS),
        .TIME_W    (TIME_W)
    ) u_slots (
        .clk          (clk_i),
        .rst          (rst_i),
        .arm_en       (arm_en),
        .arm_slot     (req_slot_i),
        .arm_deadline (req_deadline_i),
`ifdef TIMER_SCHED_PERIODIC_EN
        .arm_period   (req_period_i),
`endif
        .cancel_en    (cancel_en),
        .cancel_slot  (req_slot_i),
        .retire_en    (retire_en),
        .retire_slot  (best_idx),
        .rd_idx       (scan_idx),
        .rd_armed     (rd_armed),
        .rd_deadline  (rd_deadline),
        .armed        (armed_o)
    );

    // Strict less-than keeps the earlier (lower) index on equal deadlines.
    always_comb begin
        expired    = cmp_valid_o && (mtime_i >= mtimecmp_o);
        take       = rd_armed && (!run_found || (rd_deadline < run_dl));
        next_found = run_found || rd_armed;
        next_dl    = take ? rd_deadline : run_dl;
        next_idx   = take ? scan_idx : run_idx;
        last       = (scan_idx == SLOT_W'(NUM_SLOTS - 1));
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        evt_valid_o = 1'b0;
        arm_en      = 1'b0;
        cancel_en   = 1'b0;
        retire_en   = 1'b0;
        scan_start  = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready_o = !expired;
                if (expired) begin
                    state_nxt = S_FIRE;
                end else if (req_valid_i) begin
                    if (req_op_e'(req_op_i) == OP_ARM) begin
                        arm_en = 1'b1;
                    end else begin
                        cancel_en = 1'b1;
                    end
                    scan_start = 1'b1;
                    state_nxt  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FIRE: begin
                evt_valid_o = 1'b1;
                if (evt_ready_i) begin
                    retire_en  = 1'b1;
                    scan_start = 1'b1;
                    state_nxt  = S_SCAN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // mtimecmp_o and best_idx are only loaded on the final scan step, so they never glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            scan_idx    <= '0;
            run_found   <= 1'b0;
            run_dl      <= '0;
            run_idx     <= '0;
            best_idx    <= '0;
            mtimecmp_o  <= TIME_W'(TIME_ALL_ONES);
            cmp_valid_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (scan_start) begin
                scan_idx  <= '0;
                run_found <= 1'b0;
            end else if (state == S_SCAN) begin
                scan_idx  <= scan_idx + 1'b1;
                run_found <= next_found;
                run_dl    <= next_dl;
                run_idx   <= next_idx;
                if (last) begin
                    mtimecmp_o  <= next_found ? next_dl : TIME_W'(TIME_ALL_ONES);
                    cmp_valid_o <= next_found;
                    best_idx    <= next_found ? next_idx : '0;
                end
            end
        end
    end

    assign evt_slot_o = best_idx;

endmodule

// File: tb/tb_timer_sched.sv
// Directed testbench for timer_sched with an expiry-order scoreboard.
// Build with TIMER_SCHED_PERIODIC_EN to also exercise periodic reload.
module tb_timer_sched;
    import timer_sched_pkg::*;

    localparam int NUM_SLOTS = 4;
    localparam int TIME_W    = 64;
    localparam int SLOT_W    = 2;
    localparam logic [63:0] ONES = '1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [TIME_W-1:0]    mtime;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_op;
    logic [SLOT_W-1:0]    req_slot;
    logic [TIME_W-1:0]    req_deadline;
`ifdef TIMER_SCHED_PERIODIC_EN
    logic [TIME_W-1:0]    req_period;
`endif
    logic [TIME_W-1:0]    mtimecmp;
    logic                 cmp_valid;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [SLOT_W-1:0]    evt_slot;
    logic [NUM_SLOTS-1:0] armed;

    int assertions = 0;
    int failures   = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    timer_sched #(
        .NUM_SLOTS (NUM_SLOTS),
        .TIME_W    (TIME_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mtime_i        (mtime),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_slot_i     (req_slot),
        .req_deadline_i (req_deadline),
`ifdef TIMER_SCHED_PERIODIC_EN
        .req_period_i   (req_period),
`endif
        .mtimecmp_o     (mtimecmp),
        .cmp_valid_o    (cmp_valid),
        .evt_valid_o    (evt_valid),
        .evt_ready_i    (evt_ready),
        .evt_slot_o     (evt_slot),
        .armed_o        (armed)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the request until accepted, returns at the negedge after acceptance.
    task automatic applyStimulus(input logic op, input int slot, input logic [63:0] deadline);
        bit accepted = 1'b0;
        req_valid    = 1'b1;
        req_op       = op;
        req_slot     = SLOT_W'(slot);
        req_deadline = deadline;
        for (int i = 0; i < 200 && !accepted; i++) begin
            #1;
            if (req_ready) accepted = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("req_accept", 64'(accepted), 64'd1);
    endtask

    task automatic waitScan();
        repeat (NUM_SLOTS) @(negedge clk);
    endtask

    task automatic waitEvent(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (evt_valid) seen = 1'b1;
        end
        checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    // Waits for the next event, compares against the scoreboard head, then acknowledges it.
    task automatic expectEvent(input string tag);
        int unsigned want = 0;
        waitEvent(tag);
        checkOutput({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) want = exp_q.pop_front();
        checkOutput({tag, "_slot"}, 64'(evt_slot), 64'(want));
        checkOutput({tag, "_req_stall"}, 64'(req_ready), 64'd0);
        evt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        evt_ready = 1'b0;
        checkOutput({tag, "_drop"}, 64'(evt_valid), 64'd0);
    endtask

    task automatic pulseReset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput({tag, "_mtimecmp"}, mtimecmp, ONES);
        checkOutput({tag, "_cmp_valid"}, 64'(cmp_valid), 64'd0);
        checkOutput({tag, "_evt_valid"}, 64'(evt_valid), 64'd0);
        checkOutput({tag, "_evt_slot"}, 64'(evt_slot), 64'd0);
        checkOutput({tag, "_armed"}, 64'(armed), 64'd0);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        mtime        = '0;
        req_valid    = 1'b0;
        req_op       = 1'b0;
        req_slot     = '0;
        req_deadline = '0;
        evt_ready    = 1'b0;
`ifdef TIMER_SCHED_PERIODIC_EN
        req_period   = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mtimecmp", mtimecmp, ONES);
        checkOutput("rst_cmp_valid", 64'(cmp_valid), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_evt_valid", 64'(evt_valid), 64'd0);
        checkOutput("rst_armed", 64'(armed), 64'd0);

        $display("[TB] earliest-first ordering and scan latency");
        applyStimulus(OP_ARM, 2, 64'd100);
        checkOutput("lat_armed_t1", 64'(armed), 64'b0100);
        checkOutput("lat_scan_stall", 64'(req_ready), 64'd0);
        repeat (NUM_SLOTS - 1) @(negedge clk);
        checkOutput("lat_no_glitch", mtimecmp, ONES);
        @(negedge clk);
        checkOutput("lat_mtimecmp", mtimecmp, 64'd100);
        checkOutput("lat_cmp_valid", 64'(cmp_valid), 64'd1);
        applyStimulus(OP_ARM, 0, 64'd50);
        exp_q.push_back(0);
        exp_q.push_back(2);
        waitScan();
        checkOutput("order_cmp50", mtimecmp, 64'd50);
        mtime = 64'd49;
        repeat (3) @(negedge clk);
        checkOutput("order_early", 64'(evt_valid), 64'd0);
        mtime = 64'd50;
        expectEvent("order_ev0");
        waitScan();
        checkOutput("order_cmp100", mtimecmp, 64'd100);
        checkOutput("order_armed", 64'(armed), 64'b0100);
        mtime = 64'd100;
        expectEvent("order_ev2");
        waitScan();
        checkOutput("order_none_cmp", mtimecmp, ONES);
        checkOutput("order_none_valid", 64'(cmp_valid), 64'd0);

        $display("[TB] equal deadlines go to the lower slot first");
        mtime = 64'd0;
        applyStimulus(OP_ARM, 1, 64'd30);
        applyStimulus(OP_ARM, 3, 64'd30);
        exp_q.push_back(1);
        exp_q.push_back(3);
        waitScan();
        checkOutput("tie_cmp", mtimecmp, 64'd30);
        mtime = 64'd30;
        expectEvent("tie_ev1");
        expectEvent("tie_ev3");
        waitScan();
        checkOutput("tie_cmp_valid", 64'(cmp_valid), 64'd0);
        checkOutput("tie_armed", 64'(armed), 64'd0);

        $display("[TB] cancel before expiry and cancel of an unarmed slot");
        mtime = 64'd0;
        applyStimulus(OP_ARM, 0, 64'd200);
        waitScan();
        checkOutput("cancel_cmp_before", mtimecmp, 64'd200);
        mtime = 64'd150;
        applyStimulus(OP_CANCEL, 0, 64'd0);
        waitScan();
        checkOutput("cancel_cmp", mtimecmp, ONES);
        checkOutput("cancel_cmp_valid", 64'(cmp_valid), 64'd0);
        checkOutput("cancel_armed", 64'(armed), 64'd0);
        mtime = 64'd250;
        repeat (5) @(negedge clk);
        checkOutput("cancel_no_evt", 64'(evt_valid), 64'd0);
        applyStimulus(OP_ARM, 1, 64'd1000);
        waitScan();
        applyStimulus(OP_CANCEL, 2, 64'd0);
        checkOutput("noop_cancel_armed", 64'(armed), 64'b0010);
        waitScan();
        checkOutput("noop_cancel_cmp", mtimecmp, 64'd1000);
        applyStimulus(OP_CANCEL, 1, 64'd0);
        waitScan();

        $display("[TB] event back-pressure stalls requests");
        mtime = 64'd0;
        applyStimulus(OP_ARM, 3, 64'd20);
        waitScan();
        exp_q.push_back(3);
        mtime = 64'd20;
        waitEvent("stall");
        req_valid    = 1'b1;
        req_op       = OP_ARM;
        req_slot     = SLOT_W'(0);
        req_deadline = 64'd500;
        begin
            int unsigned want = 0;
            checkOutput("stall_sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) want = exp_q.pop_front();
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checkOutput("stall_evt_valid", 64'(evt_valid), 64'd1);
                checkOutput("stall_evt_slot", 64'(evt_slot), 64'(want));
                checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
            end
        end
        evt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        evt_ready = 1'b0;
        checkOutput("stall_drop", 64'(evt_valid), 64'd0);
        applyStimulus(OP_ARM, 0, 64'd500);
        checkOutput("stall_armed", 64'(armed), 64'b0001);
        waitScan();
        checkOutput("stall_cmp", mtimecmp, 64'd500);

        $display("[TB] reset during SCAN and during FIRE");
        applyStimulus(OP_ARM, 1, 64'd40);
        checkOutput("rscan_armed_pre", 64'(armed), 64'b0011);
        pulseReset("rst_scan");
        mtime = 64'd10;
        applyStimulus(OP_ARM, 2, 64'd5);
        waitEvent("rfire");
        checkOutput("rfire_slot_pre", 64'(evt_slot), 64'd2);
        pulseReset("rst_fire");

`ifdef TIMER_SCHED_PERIODIC_EN
        $display("[TB] periodic reload");
        mtime      = 64'd0;
        req_period = 64'd20;
        applyStimulus(OP_ARM, 1, 64'd10);
        req_period = 64'd0;
        waitScan();
        exp_q.push_back(1);
        exp_q.push_back(1);
        exp_q.push_back(1);
        mtime = 64'd10;
        expectEvent("per_ev10");
        waitScan();
        checkOutput("per_cmp30", mtimecmp, 64'd30);
        checkOutput("per_armed", 64'(armed), 64'b0010);
        mtime = 64'd30;
        expectEvent("per_ev30");
        waitScan();
        checkOutput("per_cmp50", mtimecmp, 64'd50);
        mtime = 64'd50;
        expectEvent("per_ev50");
        applyStimulus(OP_CANCEL, 1, 64'd0);
        waitScan();
        checkOutput("per_cancel_valid", 64'(cmp_valid), 64'd0);
`endif

        checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
